// File: rtl/skid_fifo_if.sv
// Valid/ready stream bundle for skid_fifo: upstream (data_in*) and downstream (data_out*) handshakes.
// The master modport is the environment side; the slave modport is the buffer side.
interface skid_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_ready;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/skid_fifo.sv
// DEPTH-entry elastic valid/ready buffer: head entry in the data_out register, the rest in a circular array.
// Optional synchronous flush port enabled by defining SKID_FIFO_FLUSH_EN.
module skid_fifo #(
    parameter int  DATA_WIDTH         = 32,
    parameter int  DEPTH              = 4,
    parameter int  ALMOST_FULL_THRESH = 3,
    localparam int CW                 = $clog2(DEPTH + 1),
    localparam int AW                 = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SKID_FIFO_FLUSH_EN
    input  logic          flush,
`endif
    skid_fifo_if.slave    bus,
    output logic [CW-1:0] count,
    output logic          almost_full
);
    localparam int            ASIZE    = DEPTH - 1;
    localparam logic [CW-1:0] ZERO_CNT = CW'(1'b0);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1'b1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] mem_q [ASIZE];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic                  push_s, pop_s, mem_we_s;

    // Array pointers wrap at DEPTH-2, so DEPTH-1 need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == LAST_PTR) begin
            return AW'(1'b0);
        end else begin
            return p + AW'(1'b1);
        end
    endfunction

    assign push_s = bus.data_in_valid & in_ready_q;
    assign pop_s  = out_valid_q & bus.data_out_ready;

    // Next-state decode: occupancy, head register refill and array pointer movement.
    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        mem_we_s    = 1'b0;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        if (pop_s) begin
            if (count_q > ONE_CNT) begin
                data_out_d = mem_q[rd_ptr_q];
                rd_ptr_d   = ptr_inc(rd_ptr_q);
            end else if (push_s) begin
                data_out_d = bus.data_in;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push_s && (count_q == ZERO_CNT)) begin
            data_out_d  = bus.data_in;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = out_valid_q;
        end

        // Only bypass into the head register when it is (or is becoming) empty.
        if (push_s && (count_q != ZERO_CNT) && !((count_q == ONE_CNT) && pop_s)) begin
            mem_we_s = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            mem_we_s = 1'b0;
        end

`ifdef SKID_FIFO_FLUSH_EN
        if (flush) begin
            count_d     = ZERO_CNT;
            rd_ptr_d    = AW'(1'b0);
            wr_ptr_d    = AW'(1'b0);
            out_valid_d = 1'b0;
            data_out_d  = data_out_q;
            mem_we_s    = 1'b0;
        end else begin
            count_d = count_d;
        end
`endif

        in_ready_d = (count_d != FULL_CNT);
    end

    // Control and head-of-queue registers; ready is registered so it never depends on the handshake inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= ZERO_CNT;
            rd_ptr_q    <= AW'(1'b0);
            wr_ptr_q    <= AW'(1'b0);
            data_out_q  <= {DATA_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Storage array write port; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = out_valid_q;
    assign bus.data_in_ready  = in_ready_q;
    assign count              = count_q;
    assign almost_full        = (count_q >= CW'(ALMOST_FULL_THRESH));
endmodule
